// File: rtl/irq_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        MRET   = 2'd3
    } trap_state_e;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MIP_MSI_BIT = 3;
    localparam int MIP_MTI_BIT = 7;
    localparam int MIP_MEI_BIT = 11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/irq_trap_ctrl_if.sv
// Core-side bundle of the trap sequencer: irq lines, CSR view, commit stage, CSR strobes, redirect.
interface irq_trap_ctrl_if;
    logic        irq_ext;
    logic        irq_sw;
    logic        irq_timer;
    logic [31:0] csr_mie;
    logic        csr_mstatus_mie;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_is_mret;
    logic [31:0] mip_o;
    logic        mepc_we;
    logic [31:0] mepc_wdata;
    logic        mcause_we;
    logic [31:0] mcause_wdata;
    logic        mstatus_trap;
    logic        mstatus_mret;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport slave (
        input  irq_ext, irq_sw, irq_timer, csr_mie, csr_mstatus_mie, csr_mtvec, csr_mepc,
               commit_valid, commit_pc, commit_is_mret,
        output mip_o, mepc_we, mepc_wdata, mcause_we, mcause_wdata, mstatus_trap,
               mstatus_mret, flush, redirect_valid, redirect_pc, busy
    );

    modport master (
        output irq_ext, irq_sw, irq_timer, csr_mie, csr_mstatus_mie, csr_mtvec, csr_mepc,
               commit_valid, commit_pc, commit_is_mret,
        input  mip_o, mepc_we, mepc_wdata, mcause_we, mcause_wdata, mstatus_trap,
               mstatus_mret, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/irq_trap_ctrl_prio_enc.sv
// Fixed-priority encoder over the enabled interrupt lines: MEI > MSI > MTI.
module irq_prio_enc
    import trap_pkg::*;
(
    input  logic       en_ext,
    input  logic       en_sw,
    input  logic       en_timer,
    output logic       any,
    output logic [3:0] cause
);
    always_comb begin
        any   = en_ext | en_sw | en_timer;
        cause = 4'd0;
        if (en_ext)        cause = CAUSE_MEI;
        else if (en_sw)    cause = CAUSE_MSI;
        else if (en_timer) cause = CAUSE_MTI;
    end
endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode trap sequencer: takes interrupts at a commit point, writes mepc/mcause/mstatus,
// flushes and redirects fetch; also sequences mret.
module irq_trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    irq_trap_ctrl_if.slave   bus
);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    trap_state_e state;
    logic [31:0] epc_q;
    logic [3:0]  cause_q;
    logic        mepc_we_q, mcause_we_q, mstatus_trap_q, mstatus_mret_q;
    logic        flush_q, redirect_valid_q, busy_q;
    logic [31:0] redirect_pc_q;

    logic        irq_any;
    logic [3:0]  irq_cause;
    logic        trap_take, mret_take;
    logic [31:0] mtvec_base, vec_pc;
    logic        unused_mie;

    irq_prio_enc u_prio (
        .en_ext   (bus.irq_ext   & bus.csr_mie[MIP_MEI_BIT]),
        .en_sw    (bus.irq_sw    & bus.csr_mie[MIP_MSI_BIT]),
        .en_timer (bus.irq_timer & bus.csr_mie[MIP_MTI_BIT]),
        .any      (irq_any),
        .cause    (irq_cause)
    );

    assign unused_mie = ^{bus.csr_mie[31:12], bus.csr_mie[10:8], bus.csr_mie[6:4], bus.csr_mie[2:0]};

    always_comb begin
        bus.mip_o              = '0;
        bus.mip_o[MIP_MEI_BIT] = bus.irq_ext;
        bus.mip_o[MIP_MTI_BIT] = bus.irq_timer;
        bus.mip_o[MIP_MSI_BIT] = bus.irq_sw;
    end

    // Interrupt beats a simultaneous mret; the mret is replayed after the handler returns.
    assign trap_take = bus.csr_mstatus_mie & irq_any & bus.commit_valid;
    assign mret_take = bus.commit_valid & bus.commit_is_mret & ~trap_take;

    // Target uses the latched cause, so an irq dropping mid-sequence has no effect.
    assign mtvec_base = bus.csr_mtvec & WORD_MASK;
    always_comb begin
        vec_pc = mtvec_base;
        if (bus.csr_mtvec == 32'd0)
            vec_pc = RESET_VEC;
        else if (bus.csr_mtvec[1:0] == MTVEC_MODE_VECTORED)
            vec_pc = mtvec_base + {26'd0, cause_q, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            epc_q            <= '0;
            cause_q          <= '0;
            mepc_we_q        <= 1'b0;
            mcause_we_q      <= 1'b0;
            mstatus_trap_q   <= 1'b0;
            mstatus_mret_q   <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            mepc_we_q        <= 1'b0;
            mcause_we_q      <= 1'b0;
            mstatus_trap_q   <= 1'b0;
            mstatus_mret_q   <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            case (state)
                IDLE: begin
                    if (trap_take) begin
                        state          <= SAVE;
                        epc_q          <= bus.commit_pc;
                        cause_q        <= irq_cause;
                        mepc_we_q      <= 1'b1;
                        mcause_we_q    <= 1'b1;
                        mstatus_trap_q <= 1'b1;
                        flush_q        <= 1'b1;
                        busy_q         <= 1'b1;
                    end else if (mret_take) begin
                        state            <= MRET;
                        mstatus_mret_q   <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= bus.csr_mepc & WORD_MASK;
                        flush_q          <= 1'b1;
                        busy_q           <= 1'b1;
                    end
                end
                SAVE: begin
                    state            <= VECTOR;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= vec_pc;
                    flush_q          <= 1'b1;
                    busy_q           <= 1'b1;
                end
                VECTOR:  state <= IDLE;
                MRET:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mepc_we        = mepc_we_q;
    assign bus.mepc_wdata     = epc_q & WORD_MASK;
    assign bus.mcause_we      = mcause_we_q;
    assign bus.mcause_wdata   = {1'b1, 27'd0, cause_q};
    assign bus.mstatus_trap   = mstatus_trap_q;
    assign bus.mstatus_mret   = mstatus_mret_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: hand-computed CSR strobes, causes and redirect targets.
module tb_irq_trap_ctrl;
    localparam logic [31:0] RVEC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    irq_trap_ctrl_if bus ();

    irq_trap_ctrl #(.RESET_VEC(RVEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change #1 after the edge, checks sample at the negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic idle_chk(input string tag);
        samp();
        chk({tag, ".busy"},  32'(bus.busy), 32'd0);
        chk({tag, ".flush"}, 32'(bus.flush), 32'd0);
        chk({tag, ".rv"},    32'(bus.redirect_valid), 32'd0);
        chk({tag, ".mepc"},  32'(bus.mepc_we), 32'd0);
        chk({tag, ".strap"}, 32'(bus.mstatus_trap), 32'd0);
    endtask

    // Launch a trap in this cycle, then check SAVE and VECTOR cycles and the return to IDLE.
    task automatic trap_seq(input string tag, input logic [31:0] pc,
                            input logic [31:0] exp_cause, input logic [31:0] exp_tgt,
                            input bit drop_irq);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        step();
        bus.commit_valid   = 1'b0;
        bus.commit_is_mret = 1'b0;
        if (drop_irq) begin
            bus.irq_ext = 1'b0; bus.irq_sw = 1'b0; bus.irq_timer = 1'b0;
        end
        samp();
        chk({tag, ".save.mepc_we"}, 32'(bus.mepc_we), 32'd1);
        chk({tag, ".save.mepc"},    bus.mepc_wdata, pc & 32'hFFFF_FFFC);
        chk({tag, ".save.mcause_we"}, 32'(bus.mcause_we), 32'd1);
        chk({tag, ".save.mcause"},  bus.mcause_wdata, exp_cause);
        chk({tag, ".save.strap"},   32'(bus.mstatus_trap), 32'd1);
        chk({tag, ".save.smret"},   32'(bus.mstatus_mret), 32'd0);
        chk({tag, ".save.flush"},   32'(bus.flush), 32'd1);
        chk({tag, ".save.rv"},      32'(bus.redirect_valid), 32'd0);
        step();
        samp();
        chk({tag, ".vec.rv"},      32'(bus.redirect_valid), 32'd1);
        chk({tag, ".vec.pc"},      bus.redirect_pc, exp_tgt);
        chk({tag, ".vec.flush"},   32'(bus.flush), 32'd1);
        chk({tag, ".vec.mepc_we"}, 32'(bus.mepc_we), 32'd0);
        chk({tag, ".vec.busy"},    32'(bus.busy), 32'd1);
        step();
        idle_chk({tag, ".done"});
    endtask

    initial begin
        rst = 1'b1;
        bus.irq_ext = 1'b1; bus.irq_sw = 1'b0; bus.irq_timer = 1'b0;
        bus.csr_mie = 32'd0; bus.csr_mstatus_mie = 1'b0;
        bus.csr_mtvec = 32'h100; bus.csr_mepc = 32'd0;
        bus.commit_valid = 1'b0; bus.commit_pc = 32'd0; bus.commit_is_mret = 1'b0;
        step(); step();
        idle_chk("rst");
        chk("rst.mip_ext", bus.mip_o, 32'h0000_0800);
        chk("rst.mcause_we", 32'(bus.mcause_we), 32'd0);
        bus.irq_ext = 1'b0; bus.irq_sw = 1'b1; bus.irq_timer = 1'b1;
        samp();
        chk("mip.sw_tmr", bus.mip_o, 32'h0000_0088);
        rst = 1'b0;
        bus.irq_sw = 1'b0; bus.irq_timer = 1'b0;
        step();

        // Direct-mode timer trap
        bus.csr_mie = 32'h80; bus.csr_mstatus_mie = 1'b1; bus.irq_timer = 1'b1;
        trap_seq("tmr", 32'h40, 32'h8000_0007, 32'h100, 1'b0);
        bus.irq_timer = 1'b0;

        // Vectored mode, ext beats timer: 0x200 + 11*4
        bus.csr_mtvec = 32'h201; bus.csr_mie = 32'h880;
        bus.irq_ext = 1'b1; bus.irq_timer = 1'b1;
        trap_seq("vec", 32'h80, 32'h8000_000B, 32'h22C, 1'b0);
        bus.irq_ext = 1'b0; bus.irq_timer = 1'b0;
        bus.csr_mtvec = 32'h100;

        // Gating: MIE off, mie bit off, commit_valid low
        bus.irq_sw = 1'b1; bus.csr_mie = 32'h8; bus.csr_mstatus_mie = 1'b0;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h60;
        step(); idle_chk("gate.mie");
        bus.csr_mstatus_mie = 1'b1; bus.csr_mie = 32'h880;
        step(); idle_chk("gate.miebit");
        bus.csr_mie = 32'h8; bus.commit_valid = 1'b0;
        step(); idle_chk("gate.cv");
        trap_seq("gate.go", 32'h60, 32'h8000_0003, 32'h100, 1'b0);
        bus.irq_sw = 1'b0;

        // mret alone
        bus.csr_mepc = 32'h44; bus.commit_valid = 1'b1;
        bus.commit_is_mret = 1'b1; bus.commit_pc = 32'h90;
        step();
        bus.commit_valid = 1'b0; bus.commit_is_mret = 1'b0;
        samp();
        chk("mret.smret", 32'(bus.mstatus_mret), 32'd1);
        chk("mret.rv",    32'(bus.redirect_valid), 32'd1);
        chk("mret.pc",    bus.redirect_pc, 32'h44);
        chk("mret.flush", 32'(bus.flush), 32'd1);
        chk("mret.strap", 32'(bus.mstatus_trap), 32'd0);
        chk("mret.mepc_we", 32'(bus.mepc_we), 32'd0);
        step();
        idle_chk("mret.done");

        // mret colliding with software irq: trap wins, epc = mret PC
        bus.irq_sw = 1'b1; bus.csr_mie = 32'h8; bus.commit_is_mret = 1'b1;
        trap_seq("coll", 32'hA4, 32'h8000_0003, 32'h100, 1'b0);
        bus.irq_sw = 1'b0;

        // Timer drops during SAVE: latched cause 7 still used (vectored: 0x200 + 28)
        bus.csr_mtvec = 32'h201; bus.csr_mie = 32'h80; bus.irq_timer = 1'b1;
        trap_seq("drop", 32'h32, 32'h8000_0007, 32'h21C, 1'b1);

        // mtvec == 0 falls back to RESET_VEC
        bus.csr_mtvec = 32'd0; bus.irq_timer = 1'b1;
        trap_seq("rvec", 32'h30, 32'h8000_0007, RVEC, 1'b0);

        // Reset while in VECTOR
        bus.csr_mtvec = 32'h100;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h50;
        step();
        bus.commit_valid = 1'b0; bus.irq_timer = 1'b0;
        step();
        samp();
        chk("rstv.rv_before", 32'(bus.redirect_valid), 32'd1);
        rst = 1'b1;
        step();
        idle_chk("rstv.after");
        rst = 1'b0;
        step();
        idle_chk("rstv.post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
